logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU path and a debug/checksum engine.
- Arbitrates with two-way round-robin and accepts one request at a time on a valid/ready handshake.
- Drives the shared unit's operands and opcode from registered values, captures its combinational result, and returns it with the requester ID.
- Sits between the requesters and the existing structural logic unit; the unit itself is instantiated outside this block.

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 16 +
 rtl/logic_unit_arbiter.sv | 115 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings, FSM states
// and default widths.
package logic_unit_pkg;

  localparam int LU_WIDTH = 32;
  localparam int LU_OPW   = 2;

  localparam logic [1:0] LU_AND = 2'b00;
  localparam logic [1:0] LU_OR  = 2'b01;
  localparam logic [1:0] LU_XOR = 2'b10;
  localparam logic [1:0] LU_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
// The pointer register lives in the parent.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

  // ptr names the favoured requester when both are valid
  assign grant0 = enable & valid0 & (~valid1 | ~ptr);
  assign grant1 = enable & valid1 & (~valid0 |  ptr);

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external bitwise logic unit between two requesters: round-robin
// accept, registered operands to the unit, registered result back with its ID.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int OPW   = LU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [OPW-1:0]   lu_op,
  input  logic [WIDTH-1:0] lu_r,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_hs;
  logic [WIDTH-1:0] r_lu_a;
  logic [WIDTH-1:0] r_lu_b;
  logic [OPW-1:0]   r_lu_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_valid;
  logic             r_rsp_id;

  assign w_idle = (r_state == S_IDLE);

  rr_arbiter2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (r_ptr),
    .enable (w_idle),
    .grant0 (w_grant0),
    .grant1 (w_grant1)
  );

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign w_hs       = (req0_valid & w_grant0) | (req1_valid & w_grant1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are only written at a handshake, so the unit sees no toggling
  // while idle and keeps the last operation's inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_a   <= '0;
      r_lu_b   <= '0;
      r_lu_op  <= '0;
      r_rsp_id <= 1'b0;
      r_ptr    <= 1'b0;
    end else if (w_hs) begin
      r_lu_a   <= w_grant1 ? req1_a  : req0_a;
      r_lu_b   <= w_grant1 ? req1_b  : req0_b;
      r_lu_op  <= w_grant1 ? req1_op : req0_op;
      r_rsp_id <= w_grant1;
      r_ptr    <= ~w_grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_data  <= lu_r;
      r_rsp_valid <= 1'b1;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign lu_a      = r_lu_a;
  assign lu_b      = r_lu_b;
  assign lu_op     = r_lu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized bench for logic_unit_arbiter; the shared logic unit
// is modelled here and results are predicted from the opcode table.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op, lu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] lu_a, lu_b, lu_r, rsp_data;
  logic         rsp_valid, rsp_id, rsp_ready;

  int checks = 0;
  int failures = 0;

  req_t q0[$];
  req_t q1[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      LU_AND:  return a & b;
      LU_OR:   return a | b;
      LU_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Stand-in for the external structural unit
  assign lu_r = lu_ref(lu_op, lu_a, lu_b);

  logic_unit_arbiter #(.WIDTH(W), .OPW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_r(lu_r),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag, input logic exp_id, input logic [W-1:0] exp_data);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_id"}, rsp_id, exp_id);
    check({tag, "_data"}, rsp_data, exp_data);
  endtask

  task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output bit got);
    got = 0;
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      got = id ? req1_ready : req0_ready;
      tick();
    end
    if (id) req1_valid = 0;
    else    req0_valid = 0;
  endtask

  task automatic single_txn(input string tag, input logic id, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp);
    bit got;
    rsp_ready = 1;
    issue(id, op, a, b, got);
    check({tag, "_hs"}, got, 1);
    wait_rsp(tag, id, exp);
  endtask

  initial begin
    bit           got, hs0, hs1;
    logic         exp_id;
    logic [W-1:0] r1a, r1b, bp_data, exp_d;
    req_t         p, e;
    int           n_rsp, n0, n1, cyc;

    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_op = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_a = 0; req1_b = 0;

    // Reset state
    repeat (3) tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_lu_a", lu_a, 0);
    check("rst_lu_b", lu_b, 0);
    check("rst_lu_op", lu_op, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst_n = 1;
    tick();

    // Single XOR request with exact latency
    req0_valid = 1; req0_op = LU_XOR; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    tick();
    check("t1_lu_op", lu_op, 2'b10);
    check("t1_lu_a", lu_a, 32'hFFFF0000);
    check("t1_lu_b", lu_b, 32'h0F0F0F0F);
    check("t1_exec_ready0", req0_ready, 0);
    check("t1_exec_rsp_valid", rsp_valid, 0);
    req0_valid = 0; req0_a = 32'hDEADBEEF;
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 32'hF0F00F0F);
    rsp_ready = 1;
    tick();
    check("t1_rsp_done", rsp_valid, 0);
    check("t1_lu_op_hold", lu_op, 2'b10);
    rsp_ready = 0;

    // Contention from reset
    rst_n = 0;
    tick();
    rst_n = 1;
    req0_valid = 1; req0_op = LU_AND; req0_a = 32'hFFFFFFFF; req0_b = 32'h12345678;
    req1_valid = 1; req1_op = LU_OR;  req1_a = 32'h0;        req1_b = 32'h80000001;
    #1;
    check("c_ready0", req0_ready, 1);
    check("c_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; rsp_ready = 1;
    #1;
    check("c_exec_ready1", req1_ready, 0);
    wait_rsp("c_r0", 0, 32'h12345678);
    tick();
    #1;
    check("c_ready1_turn", req1_ready, 1);
    check("c_ready0_off", req0_ready, 0);
    tick();
    req1_valid = 0;
    wait_rsp("c_r1", 1, 32'h80000001);
    req0_valid = 1; req0_op = LU_XOR; req0_a = 32'h1; req0_b = 32'h3;
    req1_valid = 1; req1_op = LU_AND; req1_a = 32'h7; req1_b = 32'h5;
    tick();
    #1;
    check("c2_ready0", req0_ready, 1);
    check("c2_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_rsp("c2_r0", 0, 32'h2);
    tick();

    // Backpressure with a pending requester 1
    rsp_ready = 0;
    req0_valid = 1; req0_op = LU_OR; req0_a = 32'hA5A5A5A5; req0_b = 32'h5A5A5A5A;
    #1;
    check("bp_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    r1a = $urandom; r1b = $urandom;
    req1_valid = 1; req1_op = LU_AND; req1_a = r1a; req1_b = r1b;
    wait_rsp("bp_r0", 0, 32'hFFFFFFFF);
    bp_data = rsp_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 32'hFFFFFFFF);
      check("bp_hold_id", rsp_id, 0);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
    end
    rsp_ready = 1;
    #1;
    check("bp_ready1_resp", req1_ready, 0);
    tick();
    check("bp_rsp_done", rsp_valid, 0);
    check("bp_ready1_idle", req1_ready, 1);
    tick();
    req1_valid = 0;
    wait_rsp("bp_r1", 1, r1a & r1b);

    // NOR boundaries
    single_txn("nor_ff_0", 0, LU_NOR, 32'hFFFFFFFF, 32'h0, 32'h0);
    single_txn("nor_0_0", 1, LU_NOR, 32'h0, 32'h0, 32'hFFFFFFFF);

    // Reset during EXEC
    issue(0, LU_AND, 32'hCAFEF00D, 32'hFFFFFFFF, got);
    check("mid_hs", got, 1);
    check("mid_lu_a_loaded", lu_a, 32'hCAFEF00D);
    #2;
    rst_n = 0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_lu_a", lu_a, 0);
    check("mid_lu_b", lu_b, 0);
    check("mid_lu_op", lu_op, 0);
    check("mid_rsp_data", rsp_data, 0);
    tick();
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_rsp", rsp_valid, 0);
    end

    // Fairness soak: both requesters always valid, random payloads
    rsp_ready = 1;
    p.op = 2'($urandom_range(3)); p.a = $urandom; p.b = $urandom;
    q0.push_back(p);
    req0_op = p.op; req0_a = p.a; req0_b = p.b; req0_valid = 1;
    p.op = 2'($urandom_range(3)); p.a = $urandom; p.b = $urandom;
    q1.push_back(p);
    req1_op = p.op; req1_a = p.a; req1_b = p.b; req1_valid = 1;
    #1;
    check("mid_prio_ready0", req0_ready, 1);
    check("mid_prio_ready1", req1_ready, 0);
    exp_id = 0; n_rsp = 0; n0 = 0; n1 = 0; cyc = 0;
    while (n_rsp < 100 && cyc < 1000) begin
      #1;
      hs0 = req0_ready;
      hs1 = req1_ready;
      if (rsp_valid) begin
        check("soak_id", rsp_id, exp_id);
        if (exp_id) begin
          check("soak_q1_nonempty", q1.size() > 0, 1);
          if (q1.size() > 0) begin
            e = q1.pop_front();
            exp_d = lu_ref(e.op, e.a, e.b);
            check("soak_data1", rsp_data, exp_d);
          end
          n1++;
        end else begin
          check("soak_q0_nonempty", q0.size() > 0, 1);
          if (q0.size() > 0) begin
            e = q0.pop_front();
            exp_d = lu_ref(e.op, e.a, e.b);
            check("soak_data0", rsp_data, exp_d);
          end
          n0++;
        end
        exp_id = ~exp_id;
        n_rsp++;
      end
      tick();
      if (hs0) begin
        p.op = 2'($urandom_range(3)); p.a = $urandom; p.b = $urandom;
        q0.push_back(p);
        req0_op = p.op; req0_a = p.a; req0_b = p.b;
      end
      if (hs1) begin
        p.op = 2'($urandom_range(3)); p.a = $urandom; p.b = $urandom;
        q1.push_back(p);
        req1_op = p.op; req1_a = p.a; req1_b = p.b;
      end
      cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    check("soak_total", n_rsp, 100);
    check("soak_n0", n0, 50);
    check("soak_n1", n1, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
